// File: rtl/cga_vram_fetch.sv
// CGA/Tandy VRAM fetch sequencer: slot clock, display char/attr reads and a
// single CPU access window per character slot, all sharing one video SRAM port.
module cga_vram_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        hres_mode,
  input  logic        grph_mode,
  input  logic [13:0] crtc_ma,
  input  logic [4:0]  crtc_ra,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [14:0] ram_a,
  output logic        ram_oe,
  output logic        ram_we,
  output logic [7:0]  ram_d_out,
  input  logic [7:0]  ram_d_in,
  output logic [7:0]  vram_data,
  output logic        vram_read_char,
  output logic        vram_read_att,
  output logic        charrom_read,
  output logic        disp_pipeline,
  output logic [4:0]  clk_seq
);

  logic        mode;
  logic        started;
  logic [4:0]  last_seq;
  logic [4:0]  seq_nxt;
  logic [13:0] ma_l;
  logic [1:0]  ra_l;
  logic        grph_l;
  logic        cpu_pend;
  logic        cpu_wr_l;
  logic        unused_ra;

  // Only the two low row-address bits select a graphics bank.
  assign unused_ra = &{1'b0, crtc_ra[4:2]};

  function automatic logic [14:0] disp_addr(input logic grph, input logic [13:0] ma,
                                            input logic [1:0] ra, input logic b);
    return grph ? {ra, ma[11:0], b} : {ma, b};
  endfunction

  // Outputs are registered against the sequence value they will appear with,
  // so every strobe lines up exactly with its clk_seq count.
  always_comb begin
    last_seq = mode ? 5'd15 : 5'd31;
    seq_nxt  = clk_seq + 5'd1;
    if (!started || clk_seq == last_seq)
      seq_nxt = 5'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_seq        <= 5'd0;
      mode           <= 1'b0;
      started        <= 1'b0;
      cpu_pend       <= 1'b0;
      cpu_wr_l       <= 1'b0;
      cpu_ack        <= 1'b0;
      cpu_rdata      <= 8'd0;
      ram_a          <= 15'd0;
      ram_oe         <= 1'b0;
      ram_we         <= 1'b0;
      ram_d_out      <= 8'd0;
      vram_data      <= 8'd0;
      vram_read_char <= 1'b0;
      vram_read_att  <= 1'b0;
      charrom_read   <= 1'b0;
      disp_pipeline  <= 1'b0;
    end else begin
      started        <= 1'b1;
      clk_seq        <= seq_nxt;
      ram_oe         <= 1'b0;
      ram_we         <= 1'b0;
      cpu_ack        <= 1'b0;
      vram_read_char <= 1'b0;
      vram_read_att  <= 1'b0;
      charrom_read   <= 1'b0;
      disp_pipeline  <= (seq_nxt == last_seq);
      if (started && clk_seq == last_seq)
        mode <= hres_mode;
      case (seq_nxt)
        5'd0: begin
          ram_oe <= 1'b1;
          ram_a  <= disp_addr(grph_mode, crtc_ma, crtc_ra[1:0], 1'b0);
          ma_l   <= crtc_ma;
          ra_l   <= crtc_ra[1:0];
          grph_l <= grph_mode;
        end
        5'd2: begin
          ram_oe         <= 1'b1;
          ram_a          <= disp_addr(grph_l, ma_l, ra_l, 1'b1);
          vram_read_char <= 1'b1;
          vram_data      <= ram_d_in;
        end
        5'd3: charrom_read <= 1'b1;
        5'd4: begin
          vram_read_att <= 1'b1;
          vram_data     <= ram_d_in;
        end
        5'd6: begin
          cpu_pend <= cpu_req;
          cpu_wr_l <= cpu_we;
          if (cpu_req) begin
            ram_a <= cpu_addr;
            if (cpu_we) begin
              ram_we    <= 1'b1;
              ram_d_out <= cpu_wdata;
            end else begin
              ram_oe <= 1'b1;
            end
          end
        end
        5'd7: ram_we <= cpu_pend && cpu_wr_l;
        5'd8: begin
          cpu_ack  <= cpu_pend;
          cpu_pend <= 1'b0;
          if (cpu_pend && !cpu_wr_l)
            cpu_rdata <= ram_d_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cga_vram_fetch.sv
// Directed bench for cga_vram_fetch with a behavioural one-cycle-registered SRAM.
module tb_cga_vram_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        hres_mode, grph_mode;
  logic [13:0] crtc_ma;
  logic [4:0]  crtc_ra;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [14:0] ram_a;
  logic        ram_oe, ram_we;
  logic [7:0]  ram_d_out, ram_d_in;
  logic [7:0]  vram_data;
  logic        vram_read_char, vram_read_att, charrom_read, disp_pipeline;
  logic [4:0]  clk_seq;

  logic [7:0]  mem [0:32767];
  logic        tb_we = 1'b0;
  logic [14:0] tb_addr = 15'd0;
  logic [7:0]  tb_data = 8'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cga_vram_fetch dut (
    .clk(clk), .reset(reset), .hres_mode(hres_mode), .grph_mode(grph_mode),
    .crtc_ma(crtc_ma), .crtc_ra(crtc_ra), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_a(ram_a), .ram_oe(ram_oe), .ram_we(ram_we), .ram_d_out(ram_d_out),
    .ram_d_in(ram_d_in), .vram_data(vram_data), .vram_read_char(vram_read_char),
    .vram_read_att(vram_read_att), .charrom_read(charrom_read),
    .disp_pipeline(disp_pipeline), .clk_seq(clk_seq)
  );

  // SRAM: address sampled on one edge, data presented until the next.
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (ram_we) mem[ram_a] <= ram_d_out;
    ram_d_in <= mem[ram_a];
  end

  typedef struct {
    logic        hres;
    logic        grph;
    logic [13:0] ma;
    logic [4:0]  ra;
    logic [7:0]  cb;
    logic [7:0]  ab;
    logic [14:0] a0;
    logic [14:0] a2;
    int          period;
    int          disp;
  } vec_t;

  vec_t vecs [4];

  logic [14:0] s_addr0, s_addr2;
  logic [7:0]  s_char, s_att;
  int s_char_seq, s_att_seq, s_rom_seq, s_disp_seq, s_period, s_strobes, s_oe, s_conflict;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic poke(input logic [14:0] a, input logic [7:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  task automatic wait_seq(input logic [4:0] target);
    int n = 0;
    @(negedge clk);
    while (clk_seq != target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("wait_seq");
  endtask

  task automatic wait_seq0();
    int n = 0;
    while (clk_seq == 5'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (clk_seq != 5'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("wait_seq0");
  endtask

  // Called at a negedge where clk_seq == 0; samples one whole slot.
  task automatic run_slot();
    int k = 0;
    s_char_seq = -1; s_att_seq = -1; s_rom_seq = -1; s_disp_seq = -1;
    s_strobes = 0; s_oe = 0; s_conflict = 0;
    s_addr0 = '0; s_addr2 = '0; s_char = '0; s_att = '0;
    do begin
      if (clk_seq == 5'd0) s_addr0 = ram_a;
      if (clk_seq == 5'd2) s_addr2 = ram_a;
      if (vram_read_char) begin s_char_seq = int'(clk_seq); s_char = vram_data; end
      if (vram_read_att)  begin s_att_seq  = int'(clk_seq); s_att  = vram_data; end
      if (charrom_read)   s_rom_seq  = int'(clk_seq);
      if (disp_pipeline)  s_disp_seq = int'(clk_seq);
      s_strobes += int'(vram_read_char) + int'(vram_read_att) + int'(charrom_read) + int'(disp_pipeline);
      s_oe      += int'(ram_oe);
      if (ram_oe && ram_we) s_conflict++;
      @(negedge clk);
      k++;
    end while (clk_seq != 5'd0 && k < 40);
    s_period = k;
  endtask

  initial begin
    int n;
    int maxs;
    int acks;
    vecs[0] = '{1'b0, 1'b0, 14'h0123, 5'd0,      8'h41, 8'h1F, 15'h0246, 15'h0247, 32, 31};
    vecs[1] = '{1'b1, 1'b1, 14'h0005, 5'd1,      8'h5A, 8'hC3, 15'h200A, 15'h200B, 16, 15};
    vecs[2] = '{1'b1, 1'b0, 14'h3FFF, 5'd0,      8'hFF, 8'h80, 15'h7FFE, 15'h7FFF, 16, 15};
    vecs[3] = '{1'b0, 1'b1, 14'h2ABC, 5'b10110,  8'h33, 8'hCC, 15'h5578, 15'h5579, 32, 31};

    reset = 1'b1; hres_mode = 1'b0; grph_mode = 1'b0; crtc_ma = '0; crtc_ra = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      poke(vecs[i].a0, vecs[i].cb);
      poke(vecs[i].a2, vecs[i].ab);
    end
    poke(15'h1235, 8'h77);
    poke(15'h0555, 8'h6E);

    check("reset_clk_seq", clk_seq, 0);
    check("reset_ram_oe", ram_oe, 0);
    check("reset_ram_we", ram_we, 0);
    check("reset_ram_a", ram_a, 0);
    check("reset_vram_data", vram_data, 0);
    check("reset_cpu_ack", cpu_ack, 0);
    check("reset_cpu_rdata", cpu_rdata, 0);
    check("reset_strobes", {vram_read_char, vram_read_att, charrom_read, disp_pipeline}, 0);

    reset = 1'b0;
    @(negedge clk);
    check("first_slot_seq", clk_seq, 0);
    check("first_slot_oe", ram_oe, 1);

    for (int i = 0; i < 4; i++) begin
      hres_mode = vecs[i].hres;
      grph_mode = vecs[i].grph;
      crtc_ma   = vecs[i].ma;
      crtc_ra   = vecs[i].ra;
      wait_seq0();
      wait_seq0();
      run_slot();
      check($sformatf("v%0d_addr0", i), s_addr0, vecs[i].a0);
      check($sformatf("v%0d_addr2", i), s_addr2, vecs[i].a2);
      check($sformatf("v%0d_char_seq", i), s_char_seq, 2);
      check($sformatf("v%0d_char", i), s_char, vecs[i].cb);
      check($sformatf("v%0d_att_seq", i), s_att_seq, 4);
      check($sformatf("v%0d_att", i), s_att, vecs[i].ab);
      check($sformatf("v%0d_rom_seq", i), s_rom_seq, 3);
      check($sformatf("v%0d_disp_seq", i), s_disp_seq, vecs[i].disp);
      check($sformatf("v%0d_period", i), s_period, vecs[i].period);
      check($sformatf("v%0d_strobes", i), s_strobes, 4);
      check($sformatf("v%0d_oe_cycles", i), s_oe, 2);
      check($sformatf("v%0d_oe_we", i), s_conflict, 0);
    end

    // CPU write, raised at seq 1 of a lowres slot
    hres_mode = 1'b0; grph_mode = 1'b0;
    wait_seq0(); wait_seq0();
    wait_seq(5'd1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'hA5;
    wait_seq(5'd6);
    check("wr_s6_we", ram_we, 1);
    check("wr_s6_oe", ram_oe, 0);
    check("wr_s6_addr", ram_a, 15'h1234);
    check("wr_s6_data", ram_d_out, 8'hA5);
    check("wr_s6_ack", cpu_ack, 0);
    @(negedge clk);
    check("wr_s7_we", ram_we, 1);
    @(negedge clk);
    check("wr_s8_seq", clk_seq, 8);
    check("wr_s8_ack", cpu_ack, 1);
    check("wr_s8_we", ram_we, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    check("wr_ack_width", cpu_ack, 0);
    crtc_ma = 14'h091A;
    wait_seq0(); wait_seq0();
    run_slot();
    check("wr_readback_char", s_char, 8'hA5);
    check("wr_readback_att", s_att, 8'h77);

    // CPU read raised at seq 6 misses this window
    wait_seq(5'd6);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0555;
    n = 0;
    while (!cpu_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("rd_ack");
    check("rd_latency", n, 34);
    check("rd_seq", clk_seq, 8);
    check("rd_data", cpu_rdata, 8'h6E);
    cpu_req = 1'b0;

    // Mid-slot mode change waits for the wrap
    wait_seq0();
    wait_seq(5'd10);
    hres_mode = 1'b1;
    maxs = 0; n = 0;
    while (clk_seq != 5'd0 && n < 100) begin
      if (int'(clk_seq) > maxs) maxs = int'(clk_seq);
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("mode_wrap");
    check("mode_old_slot_max", maxs, 31);
    run_slot();
    check("mode_new_period", s_period, 16);
    hres_mode = 1'b0;
    wait_seq0(); wait_seq0();

    // Reset during a CPU write
    wait_seq(5'd4);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_wdata = 8'h3C;
    wait_seq(5'd6);
    check("rst_wr_we_before", ram_we, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_wr_we_after", ram_we, 0);
    check("rst_wr_seq", clk_seq, 0);
    check("rst_wr_ack", cpu_ack, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    check("rst_wr_no_ack", acks, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
